// File: rtl/rename_map_unit.sv
// Multi-way register rename with a speculative map, a retirement map and a circular free list.
// A committed-head pointer into the free list lets a flush restore the retired state in one cycle.
module rename_map_unit #(
    parameter int ARCH_REG_NUM_WIDTH     = 5,
    parameter int PHYSICAL_REG_NUM_WIDTH = 6,
    parameter int RENAME_WIDTH           = 2,
    parameter int COMMIT_WIDTH           = 2
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [RENAME_WIDTH-1:0]                          rn_valid,
    input  logic [RENAME_WIDTH-1:0]                          rn_regwrite,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       rn_arch_src1,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       rn_arch_src2,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       rn_arch_dst,
    output logic                                             rn_ready,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   rn_phy_src1,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   rn_phy_src2,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   rn_phy_dst,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   rn_phy_old_dst,
    input  logic [COMMIT_WIDTH-1:0]                          cm_valid,
    input  logic [COMMIT_WIDTH-1:0]                          cm_regwrite,
    input  logic [COMMIT_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       cm_arch_dst,
    input  logic [COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   cm_phy_dst,
    input  logic [COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   cm_phy_old_dst,
    input  logic                                             flush,
    output logic [PHYSICAL_REG_NUM_WIDTH:0]                  free_count
);
    localparam int AW = ARCH_REG_NUM_WIDTH;
    localparam int PW = PHYSICAL_REG_NUM_WIDTH;
    localparam int RW = RENAME_WIDTH;
    localparam int CW = COMMIT_WIDTH;
    localparam int NA = 1 << AW;
    localparam int NP = 1 << PW;
    localparam logic [PW:0] FREE_INIT = (PW+1)'(NP - NA);

    logic [PW-1:0] spec_map_q  [NA];
    logic [PW-1:0] spec_map_d  [NA];
    logic [PW-1:0] ret_map_q   [NA];
    logic [PW-1:0] ret_map_d   [NA];
    logic [PW-1:0] free_list_q [NP];
    logic [PW-1:0] free_list_d [NP];
    logic [PW-1:0] head_q, head_d, commit_head_q, commit_head_d, tail_q, tail_d;
    logic [PW:0]   free_count_q, free_count_d;

    logic [AW-1:0] a_src1 [RW];
    logic [AW-1:0] a_src2 [RW];
    logic [AW-1:0] a_dst  [RW];
    logic [PW-1:0] p_dst  [RW];
    logic [PW-1:0] p_src1 [RW];
    logic [PW-1:0] p_src2 [RW];
    logic [PW-1:0] p_old  [RW];
    logic [RW-1:0] alloc;
    logic [PW:0]   n_alloc, n_free;
    logic [PW-1:0] alloc_idx, free_idx;
    logic [AW-1:0] c_arch;
    logic          fire;

    always_comb begin : rename_c
        n_alloc        = '0;
        alloc          = '0;
        alloc_idx      = '0;
        rn_phy_src1    = '0;
        rn_phy_src2    = '0;
        rn_phy_dst     = '0;
        rn_phy_old_dst = '0;
        for (int j = 0; j < RW; j++) begin
            a_src1[j] = rn_arch_src1[j*AW +: AW];
            a_src2[j] = rn_arch_src2[j*AW +: AW];
            a_dst[j]  = rn_arch_dst[j*AW +: AW];
            alloc[j]  = rn_valid[j] & rn_regwrite[j] & (a_dst[j] != '0);
            p_dst[j]  = '0;
            if (alloc[j]) begin
                alloc_idx = head_q + n_alloc[PW-1:0];
                p_dst[j]  = free_list_q[alloc_idx];
                n_alloc   = n_alloc + (PW+1)'(1);
            end
        end
        // Older allocating slots in the same group shadow the speculative map; the youngest wins.
        for (int j = 0; j < RW; j++) begin
            p_src1[j] = spec_map_q[a_src1[j]];
            p_src2[j] = spec_map_q[a_src2[j]];
            p_old[j]  = spec_map_q[a_dst[j]];
            for (int k = 0; k < j; k++) begin
                if (alloc[k] && a_dst[k] == a_src1[j]) p_src1[j] = p_dst[k];
                if (alloc[k] && a_dst[k] == a_src2[j]) p_src2[j] = p_dst[k];
                if (alloc[k] && a_dst[k] == a_dst[j])  p_old[j]  = p_dst[k];
            end
            if (a_src1[j] == '0) p_src1[j] = '0;
            if (a_src2[j] == '0) p_src2[j] = '0;
            if (a_dst[j] == '0)  p_old[j]  = '0;
            rn_phy_src1[j*PW +: PW]    = p_src1[j];
            rn_phy_src2[j*PW +: PW]    = p_src2[j];
            rn_phy_dst[j*PW +: PW]     = p_dst[j];
            rn_phy_old_dst[j*PW +: PW] = p_old[j];
        end
    end

    assign rn_ready = (free_count_q >= n_alloc) && !flush;
    assign fire     = rn_ready && (|rn_valid);

    always_comb begin : commit_c
        ret_map_d   = ret_map_q;
        free_list_d = free_list_q;
        n_free      = '0;
        free_idx    = '0;
        c_arch      = '0;
        for (int c = 0; c < CW; c++) begin
            c_arch = cm_arch_dst[c*AW +: AW];
            if (cm_valid[c] && cm_regwrite[c] && c_arch != '0) begin
                ret_map_d[c_arch]     = cm_phy_dst[c*PW +: PW];
                free_idx              = tail_q + n_free[PW-1:0];
                free_list_d[free_idx] = cm_phy_old_dst[c*PW +: PW];
                n_free                = n_free + (PW+1)'(1);
            end
        end
        tail_d        = tail_q + n_free[PW-1:0];
        commit_head_d = commit_head_q + n_free[PW-1:0];
    end

    always_comb begin : next_c
        spec_map_d   = spec_map_q;
        head_d       = head_q;
        free_count_d = free_count_q + n_free;
        if (flush) begin
            // Everything between the committed head and the tail is free again.
            spec_map_d   = ret_map_d;
            head_d       = commit_head_d;
            free_count_d = FREE_INIT;
        end else if (fire) begin
            for (int j = 0; j < RW; j++) begin
                if (alloc[j]) spec_map_d[a_dst[j]] = p_dst[j];
            end
            head_d       = head_q + n_alloc[PW-1:0];
            free_count_d = free_count_q - n_alloc + n_free;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NA; i++) begin
                spec_map_q[i] <= PW'(i);
                ret_map_q[i]  <= PW'(i);
            end
            for (int i = 0; i < NP; i++) free_list_q[i] <= PW'(i + NA);
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= PW'(NP - NA);
            free_count_q  <= FREE_INIT;
        end else begin
            spec_map_q    <= spec_map_d;
            ret_map_q     <= ret_map_d;
            free_list_q   <= free_list_d;
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            free_count_q  <= free_count_d;
        end
    end

    assign free_count = free_count_q;
endmodule

// File: tb/tb_rename_map_unit.sv
// Bench for rename_map_unit: directed vector table, hand sequences for multi-cycle corners,
// then random rename/commit/flush traffic checked against a queue-based reference model.
module tb_rename_map_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, flush;
    logic [1:0]      rn_valid, rn_regwrite;
    logic [1:0][4:0] s1, s2, d;
    logic            rn_ready;
    logic [11:0]     rn_phy_src1, rn_phy_src2, rn_phy_dst, rn_phy_old_dst;
    logic [1:0]      cm_valid, cm_regwrite;
    logic [1:0][4:0] ca;
    logic [1:0][5:0] cp, co;
    logic [6:0]      free_count;

    rename_map_unit dut (
        .clk(clk), .reset(reset),
        .rn_valid(rn_valid), .rn_regwrite(rn_regwrite),
        .rn_arch_src1(s1), .rn_arch_src2(s2), .rn_arch_dst(d),
        .rn_ready(rn_ready),
        .rn_phy_src1(rn_phy_src1), .rn_phy_src2(rn_phy_src2),
        .rn_phy_dst(rn_phy_dst), .rn_phy_old_dst(rn_phy_old_dst),
        .cm_valid(cm_valid), .cm_regwrite(cm_regwrite),
        .cm_arch_dst(ca), .cm_phy_dst(cp), .cm_phy_old_dst(co),
        .flush(flush), .free_count(free_count)
    );

    int nerr = 0;
    int nchk = 0;

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int o_dst(input int j);  return int'(rn_phy_dst[j*6 +: 6]);     endfunction
    function automatic int o_s1(input int j);   return int'(rn_phy_src1[j*6 +: 6]);    endfunction
    function automatic int o_s2(input int j);   return int'(rn_phy_src2[j*6 +: 6]);    endfunction
    function automatic int o_old(input int j);  return int'(rn_phy_old_dst[j*6 +: 6]); endfunction

    // Reference model: maps as arrays, free registers as an ordered queue, in-flight
    // allocations as a ROB queue that a flush hands back to the front of the free queue.
    typedef struct { int a; int p; int o; } rob_t;
    int   spec [32];
    int   ret  [32];
    int   avail[$];
    rob_t rob  [$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin spec[i] = i; ret[i] = i; end
        avail.delete();
        for (int i = 32; i < 64; i++) avail.push_back(i);
        rob.delete();
    endtask

    task automatic run_cycle();
        int tmp[32];
        int na;
        int pd[2], ps1[2], ps2[2], po[2];
        bit al[2];
        bit rdy, fire;
        rob_t e;
        #1;
        if (reset) begin
            model_reset();
            return;
        end
        check("free_count", int'(free_count), avail.size());
        tmp = spec;
        na  = 0;
        for (int j = 0; j < 2; j++) begin
            al[j]  = rn_valid[j] && rn_regwrite[j] && d[j] != 0;
            ps1[j] = (s1[j] == 0) ? 0 : tmp[s1[j]];
            ps2[j] = (s2[j] == 0) ? 0 : tmp[s2[j]];
            po[j]  = (d[j] == 0) ? 0 : tmp[d[j]];
            pd[j]  = 0;
            if (al[j]) begin
                pd[j] = (na < avail.size()) ? avail[na] : -1;
                na++;
                tmp[d[j]] = pd[j];
            end
        end
        rdy = (na <= avail.size()) && !flush;
        check("rn_ready", int'(rn_ready), int'(rdy));
        if (rdy) begin
            for (int j = 0; j < 2; j++) begin
                if (rn_valid[j]) begin
                    check($sformatf("dst%0d", j), o_dst(j), pd[j]);
                    check($sformatf("src1_%0d", j), o_s1(j), ps1[j]);
                    check($sformatf("src2_%0d", j), o_s2(j), ps2[j]);
                    check($sformatf("old%0d", j), o_old(j), po[j]);
                end
            end
        end
        fire = rdy && rn_valid != 0;
        if (fire) begin
            spec = tmp;
            for (int j = 0; j < 2; j++) begin
                if (al[j]) begin
                    e.a = int'(d[j]); e.p = avail.pop_front(); e.o = po[j];
                    rob.push_back(e);
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (cm_valid[c] && cm_regwrite[c] && ca[c] != 0) begin
                ret[ca[c]] = int'(cp[c]);
                avail.push_back(int'(co[c]));
                if (rob.size() > 0) void'(rob.pop_front());
            end
        end
        if (flush) begin
            spec = ret;
            for (int i = rob.size() - 1; i >= 0; i--) avail.push_front(rob[i].p);
            rob.delete();
        end
    endtask

    task automatic clear_inputs();
        reset = 0; flush = 0;
        rn_valid = '0; rn_regwrite = '0; s1 = '0; s2 = '0; d = '0;
        cm_valid = '0; cm_regwrite = '0; ca = '0; cp = '0; co = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic set_rn(input int j, input bit w, input int dd, input int a, input int b);
        rn_valid[j] = 1'b1; rn_regwrite[j] = w;
        d[j] = 5'(dd); s1[j] = 5'(a); s2[j] = 5'(b);
    endtask

    task automatic set_cm(input int c, input int a, input int p, input int o);
        cm_valid[c] = 1'b1; cm_regwrite[c] = 1'b1;
        ca[c] = 5'(a); cp[c] = 6'(p); co[c] = 6'(o);
    endtask

    typedef struct {
        logic rst, fl;
        logic [1:0] v, w;
        logic [1:0][4:0] dd, a1, a2;
        logic chk, rdy;
        logic [6:0] fc;
        logic [1:0][5:0] ed, e1, e2, eo;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic fl, input logic [1:0] v, input logic [1:0] w,
                           input logic [1:0][4:0] dd, input logic [1:0][4:0] a1, input logic [1:0][4:0] a2,
                           input logic chk, input logic rdy, input logic [6:0] fc,
                           input logic [1:0][5:0] ed, input logic [1:0][5:0] e1,
                           input logic [1:0][5:0] e2, input logic [1:0][5:0] eo);
        vec_t t;
        t.rst = rst; t.fl = fl; t.v = v; t.w = w; t.dd = dd; t.a1 = a1; t.a2 = a2;
        t.chk = chk; t.rdy = rdy; t.fc = fc; t.ed = ed; t.e1 = e1; t.e2 = e2; t.eo = eo;
        vecs.push_back(t);
    endtask

    initial begin
        int ridx;
        clear_inputs();
        reset = 1;
        // rst fl v w dst{1,0} src1{1,0} src2{1,0} | chk rdy fc dst src1 src2 old
        add_vec(1, 0, 2'b00, 2'b00, {5'd0, 5'd0}, {5'd0, 5'd0}, {5'd0, 5'd0},
                0, 0, 0, {6'd0, 6'd0}, {6'd0, 6'd0}, {6'd0, 6'd0}, {6'd0, 6'd0});
        add_vec(0, 0, 2'b11, 2'b11, {5'd2, 5'd1}, {5'd1, 5'd0}, {5'd1, 5'd0},
                1, 1, 32, {6'd33, 6'd32}, {6'd32, 6'd0}, {6'd32, 6'd0}, {6'd2, 6'd1});
        add_vec(0, 0, 2'b00, 2'b00, {5'd0, 5'd0}, {5'd0, 5'd0}, {5'd0, 5'd0},
                1, 1, 30, {6'd0, 6'd0}, {6'd0, 6'd0}, {6'd0, 6'd0}, {6'd0, 6'd0});
        add_vec(1, 0, 2'b00, 2'b00, {5'd0, 5'd0}, {5'd0, 5'd0}, {5'd0, 5'd0},
                0, 0, 0, {6'd0, 6'd0}, {6'd0, 6'd0}, {6'd0, 6'd0}, {6'd0, 6'd0});
        add_vec(0, 0, 2'b11, 2'b11, {5'd3, 5'd3}, {5'd3, 5'd0}, {5'd3, 5'd0},
                1, 1, 32, {6'd33, 6'd32}, {6'd32, 6'd0}, {6'd32, 6'd0}, {6'd32, 6'd3});
        add_vec(0, 0, 2'b01, 2'b00, {5'd0, 5'd0}, {5'd0, 5'd3}, {5'd0, 5'd3},
                1, 1, 30, {6'd0, 6'd0}, {6'd0, 6'd33}, {6'd0, 6'd33}, {6'd0, 6'd0});
        add_vec(0, 1, 2'b01, 2'b01, {5'd0, 5'd4}, {5'd0, 5'd0}, {5'd0, 5'd0},
                1, 0, 30, {6'd0, 6'd0}, {6'd0, 6'd0}, {6'd0, 6'd0}, {6'd0, 6'd0});
        add_vec(0, 0, 2'b01, 2'b00, {5'd0, 5'd0}, {5'd0, 5'd3}, {5'd0, 5'd1},
                1, 1, 32, {6'd0, 6'd0}, {6'd0, 6'd3}, {6'd0, 6'd1}, {6'd0, 6'd0});
        add_vec(0, 0, 2'b11, 2'b11, {5'd5, 5'd4}, {5'd4, 5'd0}, {5'd0, 5'd0},
                1, 1, 32, {6'd33, 6'd32}, {6'd32, 6'd0}, {6'd0, 6'd0}, {6'd5, 6'd4});

        foreach (vecs[i]) begin
            nxt();
            reset = vecs[i].rst; flush = vecs[i].fl;
            rn_valid = vecs[i].v; rn_regwrite = vecs[i].w;
            d = vecs[i].dd; s1 = vecs[i].a1; s2 = vecs[i].a2;
            run_cycle();
            if (vecs[i].chk) begin
                check($sformatf("v%0d_fc", i), int'(free_count), int'(vecs[i].fc));
                check($sformatf("v%0d_rdy", i), int'(rn_ready), int'(vecs[i].rdy));
                for (int j = 0; j < 2; j++) begin
                    if (vecs[i].rdy && vecs[i].v[j]) begin
                        check($sformatf("v%0d_dst%0d", i, j), o_dst(j), int'(vecs[i].ed[j]));
                        check($sformatf("v%0d_s1_%0d", i, j), o_s1(j), int'(vecs[i].e1[j]));
                        check($sformatf("v%0d_s2_%0d", i, j), o_s2(j), int'(vecs[i].e2[j]));
                        check($sformatf("v%0d_old%0d", i, j), o_old(j), int'(vecs[i].eo[j]));
                    end
                end
            end
        end

        // Exhaustion: 16 two-write groups drain the free list.
        nxt(); reset = 1; run_cycle();
        for (int g = 0; g < 16; g++) begin
            nxt();
            set_rn(0, 1, $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            set_rn(1, 1, $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            run_cycle();
        end
        nxt(); set_rn(0, 1, 7, 1, 2); run_cycle();
        check("exh_fc", int'(free_count), 0);
        check("exh_rdy_write", int'(rn_ready), 0);
        nxt(); set_rn(0, 0, 7, 1, 2); set_rn(1, 1, 0, 3, 4); run_cycle();
        check("exh_rdy_nowrite", int'(rn_ready), 1);
        check("exh_dst0", o_dst(0), 0);
        check("exh_dst1_x0", o_dst(1), 0);

        // Commit alongside a rename: freed register comes back only after the ring wraps.
        nxt(); reset = 1; run_cycle();
        nxt(); set_rn(0, 1, 1, 0, 0); run_cycle();
        check("c_first", o_dst(0), 32);
        nxt(); set_cm(0, 1, 32, 1); set_rn(0, 1, 5, 1, 0); run_cycle();
        check("c_dst", o_dst(0), 33);
        check("c_src", o_s1(0), 32);
        nxt(); run_cycle();
        check("c_fc", int'(free_count), 31);
        for (int g = 0; g < 15; g++) begin
            nxt(); set_rn(0, 1, $urandom_range(1, 31), 0, 0); set_rn(1, 1, $urandom_range(1, 31), 0, 0);
            run_cycle();
        end
        nxt(); set_rn(0, 1, 9, 0, 0); run_cycle();
        check("c_realloc", o_dst(0), 1);

        // Flush after a partial commit restores the retired map and the committed head.
        nxt(); reset = 1; run_cycle();
        nxt(); set_rn(0, 1, 1, 0, 0); set_rn(1, 1, 2, 0, 0); run_cycle();
        nxt(); set_rn(0, 1, 3, 0, 0); run_cycle();
        check("f_dst3", o_dst(0), 34);
        nxt(); set_cm(0, 1, 32, 1); run_cycle();
        nxt(); flush = 1; set_rn(0, 1, 4, 0, 0); run_cycle();
        check("f_rdy_flush", int'(rn_ready), 0);
        nxt(); set_rn(0, 0, 0, 1, 2); set_rn(1, 0, 0, 3, 0); run_cycle();
        check("f_x1", o_s1(0), 32);
        check("f_x2", o_s2(0), 2);
        check("f_x3", o_s1(1), 3);
        check("f_fc", int'(free_count), 32);
        nxt(); set_rn(0, 1, 6, 0, 0); run_cycle();
        check("f_alloc", o_dst(0), 33);

        // Reset wins over simultaneous flush, commit and rename.
        nxt(); set_rn(0, 1, 1, 0, 0); set_rn(1, 1, 2, 0, 0); run_cycle();
        nxt(); reset = 1; flush = 1; set_cm(0, 1, 33, 1); set_rn(0, 1, 3, 0, 0); run_cycle();
        nxt(); set_rn(0, 1, 4, 1, 2); run_cycle();
        check("r_x1", o_s1(0), 1);
        check("r_x2", o_s2(0), 2);
        check("r_fc", int'(free_count), 32);
        check("r_alloc", o_dst(0), 32);

        // Random traffic: the bench acts as the ROB, committing in allocation order.
        nxt(); reset = 1; run_cycle();
        for (int n = 0; n < 4000; n++) begin
            nxt();
            if ($urandom_range(0, 499) == 0) begin
                reset = 1;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if ($urandom_range(0, 3) != 0)
                        set_rn(j, $urandom_range(0, 3) != 0,
                               $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                               $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                               $urandom_range(0, 7));
                end
                ridx = 0;
                for (int c = 0; c < 2; c++) begin
                    case ($urandom_range(0, 3))
                        0, 1: if (ridx < rob.size()) begin
                            set_cm(c, rob[ridx].a, rob[ridx].p, rob[ridx].o);
                            ridx++;
                        end
                        2: begin
                            cm_valid[c] = 1'b1;
                            cm_regwrite[c] = 1'($urandom_range(0, 1));
                            ca[c] = cm_regwrite[c] ? 5'd0 : 5'($urandom_range(0, 31));
                            cp[c] = 6'($urandom_range(0, 63));
                            co[c] = 6'($urandom_range(0, 63));
                        end
                        default: ;
                    endcase
                end
                flush = ($urandom_range(0, 79) == 0);
            end
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
